// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the D/X hazard controller and the pipeline registers.
// The master modport is the hazard controller, and the slave modport is the pipeline/proc top side.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  // No valid/ready handshake here. *_valid only qualifies its register specifier in the same cycle.
  // Each en/flush output is a level for the current cycle; a register loads at the next edge when en=1.
  logic [2:0]       d_rs;
  logic             d_rs_valid;
  logic [2:0]       d_rt;
  logic             d_rt_valid;
  logic             x_rf_writeEn;
  logic [2:0]       x_rf_sel;
  logic             x_is_load;
  logic             x_branch_taken;
  logic             x_halt;
  logic             mem_stall;
  logic             pc_en;
  logic             fd_en;
  logic             fd_flush;
  logic             dx_en;
  logic             dx_flush;
  logic             xm_en;
  logic             mw_en;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [1:0]       fsm_state;

  modport master (
    input  d_rs, d_rs_valid, d_rt, d_rt_valid, x_rf_writeEn, x_rf_sel,
           x_is_load, x_branch_taken, x_halt, mem_stall,
    output pc_en, fd_en, fd_flush, dx_en, dx_flush, xm_en, mw_en, halted,
           stall_cnt, flush_cnt, fsm_state
  );

  modport slave (
    output d_rs, d_rs_valid, d_rt, d_rt_valid, x_rf_writeEn, x_rf_sel,
           x_is_load, x_branch_taken, x_halt, mem_stall,
    input  pc_en, fd_en, fd_flush, dx_en, dx_flush, xm_en, mw_en, halted,
           stall_cnt, flush_cnt, fsm_state
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: load-use stall, branch squash, memory freeze and halt drain.
// Optional saturating perf counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic                clk,
  input logic                rst,
  pipe_hazard_ctrl_if.master bus
);
  localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          load_use;

  assign load_use = bus.x_is_load & bus.x_rf_writeEn &
                    ((bus.d_rs_valid & (bus.d_rs == bus.x_rf_sel)) |
                     (bus.d_rt_valid & (bus.d_rt == bus.x_rf_sel)));

  assign bus.fsm_state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    bus.pc_en    = 1'b0;
    bus.fd_en    = 1'b0;
    bus.fd_flush = 1'b0;
    bus.dx_en    = 1'b0;
    bus.dx_flush = 1'b0;
    bus.xm_en    = 1'b0;
    bus.mw_en    = 1'b0;
    bus.halted   = 1'b0;
    if (!rst) begin
      // While reset is held, both the F/D and D/X stages load NOPs.
      bus.fd_flush = 1'b1;
      bus.dx_flush = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (!bus.mem_stall) begin
            if (bus.x_halt) begin
              bus.fd_en    = 1'b1;
              bus.fd_flush = 1'b1;
              bus.dx_en    = 1'b1;
              bus.dx_flush = 1'b1;
              bus.xm_en    = 1'b1;
              bus.mw_en    = 1'b1;
              state_d      = DRAIN;
              drain_d      = DW'(DRAIN_CYCLES);
            end else if (bus.x_branch_taken) begin
              bus.pc_en    = 1'b1;
              bus.fd_en    = 1'b1;
              bus.fd_flush = 1'b1;
              bus.dx_en    = 1'b1;
              bus.dx_flush = 1'b1;
              bus.xm_en    = 1'b1;
              bus.mw_en    = 1'b1;
            end else if (load_use) begin
              // PC and F/D hold. A bubble enters X, so x_is_load drops next cycle.
              bus.dx_en    = 1'b1;
              bus.dx_flush = 1'b1;
              bus.xm_en    = 1'b1;
              bus.mw_en    = 1'b1;
            end else begin
              bus.pc_en    = 1'b1;
              bus.fd_en    = 1'b1;
              bus.dx_en    = 1'b1;
              bus.xm_en    = 1'b1;
              bus.mw_en    = 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!bus.mem_stall) begin
            bus.fd_en    = 1'b1;
            bus.fd_flush = 1'b1;
            bus.dx_en    = 1'b1;
            bus.dx_flush = 1'b1;
            bus.xm_en    = 1'b1;
            bus.mw_en    = 1'b1;
            if (drain_q <= DW'(1)) begin
              state_d = HALTED;
              drain_d = '0;
            end else begin
              drain_d = drain_q - 1'b1;
            end
          end
        end
        HALTED: bus.halted = 1'b1;
        default: state_d = RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic             stall_evt, flush_evt;
  logic [CNT_W-1:0] stall_q, flush_q;

  assign stall_evt = (state_q == RUN) & ~bus.mem_stall & ~bus.x_halt &
                     ~bus.x_branch_taken & load_use;
  assign flush_evt = (state_q == RUN) & ~bus.mem_stall & ~bus.x_halt &
                     bus.x_branch_taken;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_evt && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush_evt && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
`else
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, hand-written corner sequences, and random stimulus against a reference model.
module tb_pipe_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam int DRAIN = 2;
  localparam int SAT   = (1 << CNT_W) - 1;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  // Output vector bit order: {pc_en, fd_en, fd_flush, dx_en, dx_flush, xm_en, mw_en, halted}.
  localparam logic [7:0] RESET_O   = 8'b0010_1000;
  localparam logic [7:0] NORMAL_O  = 8'b1101_0110;
  localparam logic [7:0] FREEZE_O  = 8'b0000_0000;
  localparam logic [7:0] HALT_O    = 8'b0111_1110;
  localparam logic [7:0] DRAIN_O   = 8'b0111_1110;
  localparam logic [7:0] BRANCH_O  = 8'b1111_1110;
  localparam logic [7:0] LOADUSE_O = 8'b0001_1110;
  localparam logic [7:0] HALTED_O  = 8'b0000_0001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();
  pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: whether halted, drain cycles left (-1 means not draining), and event counts.
  bit m_halted;
  int m_drain;
  int m_stall;
  int m_flush;

  typedef struct {
    logic [2:0] d_rs;
    logic       d_rs_valid;
    logic [2:0] d_rt;
    logic       d_rt_valid;
    logic       we;
    logic [2:0] sel;
    logic       ld;
    logic       br;
    logic       ms;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[12];

  logic [7:0] outv;
  assign outv = {bus.pc_en, bus.fd_en, bus.fd_flush, bus.dx_en, bus.dx_flush,
                 bus.xm_en, bus.mw_en, bus.halted};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    else n_pass++;
  endtask

  task automatic set_in(input logic [2:0] rs, input logic rsv, input logic [2:0] rt,
                        input logic rtv, input logic we, input logic [2:0] sel,
                        input logic ld, input logic br, input logic hlt, input logic ms);
    bus.d_rs = rs; bus.d_rs_valid = rsv; bus.d_rt = rt; bus.d_rt_valid = rtv;
    bus.x_rf_writeEn = we; bus.x_rf_sel = sel; bus.x_is_load = ld;
    bus.x_branch_taken = br; bus.x_halt = hlt; bus.mem_stall = ms;
  endtask

  function automatic bit hazard();
    bit hit = 1'b0;
    if (bus.d_rs_valid && bus.d_rs == bus.x_rf_sel) hit = 1'b1;
    if (bus.d_rt_valid && bus.d_rt == bus.x_rf_sel) hit = 1'b1;
    return hit && bus.x_is_load && bus.x_rf_writeEn;
  endfunction

  task automatic model_reset();
    m_halted = 1'b0; m_drain = -1; m_stall = 0; m_flush = 0;
  endtask

  function automatic logic [7:0] model_out();
    if (!rst) return RESET_O;
    if (m_halted) return HALTED_O;
    if (bus.mem_stall) return FREEZE_O;
    if (m_drain >= 0) return DRAIN_O;
    if (bus.x_halt) return HALT_O;
    if (bus.x_branch_taken) return BRANCH_O;
    if (hazard()) return LOADUSE_O;
    return NORMAL_O;
  endfunction

  task automatic model_step();
    if (m_halted || bus.mem_stall) return;
    if (m_drain >= 0) begin
      m_drain--;
      if (m_drain <= 0) begin m_halted = 1'b1; m_drain = -1; end
    end else if (bus.x_halt) m_drain = DRAIN;
    else if (bus.x_branch_taken) m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
    else if (hazard()) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
  endtask

  // One clock cycle: inputs are already driven; check, advance the model, then step past the edge.
  task automatic cycle(input string name, input bit use_model, input logic [7:0] exp_tbl);
    logic [7:0] e;
    #1;
    if (!rst) model_reset();
    e = use_model ? model_out() : exp_tbl;
    check(name, {24'h0, outv}, {24'h0, e});
    check({name, "_stall_cnt"}, {28'h0, bus.stall_cnt}, PERF_ON ? m_stall : 0);
    check({name, "_flush_cnt"}, {28'h0, bus.flush_cnt}, PERF_ON ? m_flush : 0);
    if (rst) model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, NORMAL_O};
    tbl[1]  = '{3'd3, 1'b1, 3'd1, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, LOADUSE_O};
    tbl[2]  = '{3'd3, 1'b0, 3'd1, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, NORMAL_O};
    tbl[3]  = '{3'd1, 1'b1, 3'd3, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, LOADUSE_O};
    tbl[4]  = '{3'd3, 1'b1, 3'd3, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, NORMAL_O};
    tbl[5]  = '{3'd3, 1'b1, 3'd3, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, NORMAL_O};
    tbl[6]  = '{3'd0, 1'b1, 3'd2, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, LOADUSE_O};
    tbl[7]  = '{3'd3, 1'b1, 3'd0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, BRANCH_O};
    tbl[8]  = '{3'd5, 1'b0, 3'd6, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, BRANCH_O};
    tbl[9]  = '{3'd3, 1'b1, 3'd0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, FREEZE_O};
    tbl[10] = '{3'd3, 1'b1, 3'd0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, FREEZE_O};
    tbl[11] = '{3'd3, 1'b1, 3'd5, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, NORMAL_O};

    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    cycle("reset_hold", 0, RESET_O);
    cycle("reset_hold", 0, RESET_O);
    rst = 1'b1;

    foreach (tbl[i]) begin
      set_in(tbl[i].d_rs, tbl[i].d_rs_valid, tbl[i].d_rt, tbl[i].d_rt_valid, tbl[i].we,
             tbl[i].sel, tbl[i].ld, tbl[i].br, 1'b0, tbl[i].ms);
      cycle($sformatf("vec%0d", i), 0, tbl[i].exp);
    end

    // Freeze holds off a pending load-use stall for 3 cycles; the stall then applies once.
    set_in(3, 1, 0, 0, 1, 3, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle("freeze_lu", 0, FREEZE_O);
    bus.mem_stall = 1'b0;
    cycle("freeze_release_lu", 0, LOADUSE_O);
    bus.x_is_load = 1'b0;
    cycle("after_bubble", 0, NORMAL_O);

    // Reset asserted in DRAIN takes effect immediately, without waiting for a clock edge.
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cycle("halt_enter", 0, HALT_O);
    bus.x_halt = 1'b0;
    cycle("drain1", 0, DRAIN_O);
    rst = 1'b0;
    cycle("rst_in_drain", 0, RESET_O);
    rst = 1'b1;
    cycle("rst_release", 0, NORMAL_O);

    // Halt drain, with a freeze on the second drain cycle.
    bus.x_halt = 1'b1;
    cycle("hd_run", 0, HALT_O);
    set_in(3, 1, 0, 0, 1, 3, 1, 1, 0, 0);
    cycle("hd_drain1", 0, DRAIN_O);
    bus.mem_stall = 1'b1;
    cycle("hd_frozen", 0, FREEZE_O);
    bus.mem_stall = 1'b0;
    cycle("hd_drain2", 0, DRAIN_O);
    for (int i = 0; i < 3; i++) begin
      bus.mem_stall = 1'($urandom_range(0, 1));
      cycle("hd_halted", 0, HALTED_O);
    end

    // Saturation: 20 load-use cycles after a clean reset.
    rst = 1'b0;
    cycle("sat_reset", 0, RESET_O);
    rst = 1'b1;
    set_in(2, 0, 6, 1, 1, 6, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle("sat_lu", 0, LOADUSE_O);
    check("sat_stall_final", {28'h0, bus.stall_cnt}, PERF_ON ? 32'd15 : 32'd0);

    // Random traffic against the reference model, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      logic [2:0] sel;
      rst = ($urandom_range(0, 59) != 0);
      sel = 3'($urandom_range(0, 7));
      set_in(($urandom_range(0, 1) != 0) ? sel : 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? sel : 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sel,
             1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 29) == 0), ($urandom_range(0, 4) == 0));
      cycle("rand", 1, 8'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
